// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU, MUL and MEM completions onto one ROB port.
// Each stream owns a small FIFO; the oldest head relative to rob_head wins.
module writeback_arbiter #(
   parameter int REGISTER_SIZE    = 32,
   parameter int REG_ADDRESS_SIZE = 5,
   parameter int ID_SIZE          = 3,
   parameter int FIFO_DEPTH       = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic [ID_SIZE-1:0]            rob_head,
   input  logic [2:0]                    req_valid,
   input  logic [3*REGISTER_SIZE-1:0]    req_data,
   input  logic [3*REG_ADDRESS_SIZE-1:0] req_address,
   input  logic [2:0]                    req_w,
   input  logic [3*ID_SIZE-1:0]          req_id,
   output logic [2:0]                    req_stall,
   output logic                          rob_req,
   output logic [REGISTER_SIZE-1:0]      rob_data,
   output logic [REG_ADDRESS_SIZE-1:0]   rob_address,
   output logic                          rob_w,
   output logic [ID_SIZE-1:0]            rob_id,
   input  logic                          rob_stall,
   output logic [2:0]                    pending
);

   localparam int N  = 3;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

   logic [REGISTER_SIZE-1:0]    mem_data [N][FIFO_DEPTH];
   logic [REG_ADDRESS_SIZE-1:0] mem_addr [N][FIFO_DEPTH];
   logic                        mem_w    [N][FIFO_DEPTH];
   logic [ID_SIZE-1:0]          mem_id   [N][FIFO_DEPTH];

   logic [PW-1:0] rd_ptr [N];
   logic [PW-1:0] wr_ptr [N];
   logic [CW-1:0] count  [N];

   logic [REGISTER_SIZE-1:0]    head_data [N];
   logic [REG_ADDRESS_SIZE-1:0] head_addr [N];
   logic                        head_w    [N];
   logic [ID_SIZE-1:0]          head_id   [N];

   logic [N-1:0] push, pop, nonempty, grant;
   logic         out_ready, grant_any;
   logic [ID_SIZE-1:0]          best_age;
   logic [REGISTER_SIZE-1:0]    sel_data;
   logic [REG_ADDRESS_SIZE-1:0] sel_addr;
   logic                        sel_w;
   logic [ID_SIZE-1:0]          sel_id;
   logic [CW+1:0]               total;

   assign out_ready = !rob_req || !rob_stall;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_stall[i] = (count[i] == FULL);
         nonempty[i]  = (count[i] != '0);
         push[i]      = req_valid[i] && !req_stall[i] && !flush;
         head_data[i] = mem_data[i][rd_ptr[i]];
         head_addr[i] = mem_addr[i][rd_ptr[i]];
         head_w[i]    = mem_w[i][rd_ptr[i]];
         head_id[i]   = mem_id[i][rd_ptr[i]];
      end
   end

   // Strict '<' keeps the lowest index on an age tie.
   always_comb begin
      logic [ID_SIZE-1:0] age;
      age       = '0;
      grant     = '0;
      grant_any = 1'b0;
      best_age  = '0;
      sel_data  = '0;
      sel_addr  = '0;
      sel_w     = 1'b0;
      sel_id    = '0;
      for (int i = 0; i < N; i++) begin
         age = head_id[i] - rob_head;
         if (nonempty[i] && (!grant_any || age < best_age)) begin
            grant     = '0;
            grant[i]  = 1'b1;
            grant_any = 1'b1;
            best_age  = age;
            sel_data  = head_data[i];
            sel_addr  = head_addr[i];
            sel_w     = head_w[i];
            sel_id    = head_id[i];
         end
      end
   end

   assign pop = grant & {N{out_ready}};

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (push[i]) begin
            mem_data[i][wr_ptr[i]] <=
               req_data[i*REGISTER_SIZE +: REGISTER_SIZE];
            mem_addr[i][wr_ptr[i]] <=
               req_address[i*REG_ADDRESS_SIZE +: REG_ADDRESS_SIZE];
            mem_w[i][wr_ptr[i]]    <= req_w[i];
            mem_id[i][wr_ptr[i]]   <= req_id[i*ID_SIZE +: ID_SIZE];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rob_req     <= 1'b0;
         rob_data    <= '0;
         rob_address <= '0;
         rob_w       <= 1'b0;
         rob_id      <= '0;
      end else if (flush) begin
         for (int i = 0; i < N; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rob_req <= 1'b0;
      end else begin
         for (int i = 0; i < N; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
            if (push[i] && !pop[i])
               count[i] <= count[i] + CW'(1);
            else if (pop[i] && !push[i])
               count[i] <= count[i] - CW'(1);
         end
         if (out_ready) begin
            rob_req <= grant_any;
            if (grant_any) begin
               rob_data    <= sel_data;
               rob_address <= sel_addr;
               rob_w       <= sel_w;
               rob_id      <= sel_id;
            end
         end
      end
   end

   assign total = (CW+2)'(count[0]) + (CW+2)'(count[1])
                + (CW+2)'(count[2]) + (CW+2)'(rob_req);
   assign pending = (total > (CW+2)'(7)) ? 3'd7 : total[2:0];

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter: latency, age order, wrap,
// backpressure, flush and asynchronous reset.
module tb_writeback_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [2:0]  rob_head;
   logic [2:0]  req_valid;
   logic [95:0] req_data;
   logic [14:0] req_address;
   logic [2:0]  req_w;
   logic [8:0]  req_id;
   logic [2:0]  req_stall;
   logic        rob_req;
   logic [31:0] rob_data;
   logic [4:0]  rob_address;
   logic        rob_w;
   logic [2:0]  rob_id;
   logic        rob_stall;
   logic [2:0]  pending;

   int n_checks = 0;
   int n_fail   = 0;

   writeback_arbiter dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .rob_head    (rob_head),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_address (req_address),
      .req_w       (req_w),
      .req_id      (req_id),
      .req_stall   (req_stall),
      .rob_req     (rob_req),
      .rob_data    (rob_data),
      .rob_address (rob_address),
      .rob_w       (rob_w),
      .rob_id      (rob_id),
      .rob_stall   (rob_stall),
      .pending     (pending)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] d,
                          input logic [4:0] a, input logic w,
                          input logic [2:0] id);
      req_valid[i]         = 1'b1;
      req_data[i*32 +: 32] = d;
      req_address[i*5 +: 5] = a;
      req_w[i]             = w;
      req_id[i*3 +: 3]     = id;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; rob_head = 3'd0; rob_stall = 1'b0;
      req_valid = '0; req_data = '0; req_address = '0;
      req_w = '0; req_id = '0;
      #2;
      check("rst_req", rob_req, 1'b0);
      check("rst_data", rob_data, 32'h0);
      check("rst_id", rob_id, 3'd0);
      check("rst_stall", req_stall, 3'b000);
      check("rst_pending", pending, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // single path
      set_req(0, 32'hDEADBEEF, 5'd7, 1'b1, 3'd2);
      tick();
      req_valid = '0;
      check("sp_req0", rob_req, 1'b0);
      check("sp_pend1", pending, 3'd1);
      tick();
      check("sp_req1", rob_req, 1'b1);
      check("sp_data", rob_data, 32'hDEADBEEF);
      check("sp_addr", rob_address, 5'd7);
      check("sp_w", rob_w, 1'b1);
      check("sp_id", rob_id, 3'd2);
      tick();
      check("sp_req2", rob_req, 1'b0);
      check("sp_hold", rob_data, 32'hDEADBEEF);
      check("sp_pend0", pending, 3'd0);

      // age priority, rob_head=6: MEM(1) age3, ALU(3) age5, MUL(5) age7
      rob_head = 3'd6;
      set_req(0, 32'h11, 5'd1, 1'b1, 3'd3);
      set_req(1, 32'h22, 5'd2, 1'b0, 3'd5);
      set_req(2, 32'h33, 5'd3, 1'b1, 3'd1);
      tick();
      req_valid = '0;
      check("age_pend3", pending, 3'd3);
      tick();
      check("age_1st_id", rob_id, 3'd1);
      check("age_1st_dat", rob_data, 32'h33);
      check("age_pend_a", pending, 3'd3);
      tick();
      check("age_2nd_id", rob_id, 3'd3);
      check("age_2nd_dat", rob_data, 32'h11);
      tick();
      check("age_3rd_id", rob_id, 3'd5);
      check("age_3rd_w", rob_w, 1'b0);
      tick();
      check("age_done", rob_req, 1'b0);

      // wrap: rob_head=7, MEM id7 age0 beats ALU id0 age1
      rob_head = 3'd7;
      set_req(0, 32'hA0, 5'd4, 1'b1, 3'd0);
      set_req(2, 32'hC7, 5'd5, 1'b1, 3'd7);
      tick();
      req_valid = '0;
      tick();
      check("wrap_1st", rob_id, 3'd7);
      tick();
      check("wrap_2nd", rob_id, 3'd0);
      check("wrap_2nd_req", rob_req, 1'b1);
      tick();
      check("wrap_done", rob_req, 1'b0);

      // backpressure: occupy output with ALU id0, then stall
      rob_head = 3'd0;
      set_req(0, 32'hA0, 5'd1, 1'b1, 3'd0);
      tick();
      req_valid = '0;
      tick();
      check("bp_out", rob_req, 1'b1);
      rob_stall = 1'b1;
      set_req(1, 32'hB1, 5'd9, 1'b1, 3'd1);
      tick();
      check("bp_st1", req_stall, 3'b000);
      check("bp_pend2", pending, 3'd2);
      set_req(1, 32'hB2, 5'd9, 1'b1, 3'd2);
      tick();
      check("bp_st2", req_stall, 3'b010);
      check("bp_pend3", pending, 3'd3);
      check("bp_hold_id", rob_id, 3'd0);
      set_req(1, 32'hB3, 5'd9, 1'b1, 3'd3);
      tick();
      check("bp_ignored", pending, 3'd3);
      check("bp_st3", req_stall, 3'b010);
      rob_stall = 1'b0;
      tick();
      check("bp_o1", rob_id, 3'd1);
      check("bp_o1_st", req_stall, 3'b000);
      check("bp_o1_pend", pending, 3'd2);
      tick();
      req_valid = '0;
      check("bp_o2", rob_id, 3'd2);
      check("bp_o2_pend", pending, 3'd2);
      tick();
      check("bp_o3", rob_id, 3'd3);
      check("bp_o3_dat", rob_data, 32'hB3);
      check("bp_o3_pend", pending, 3'd1);
      tick();
      check("bp_done", rob_req, 1'b0);
      check("bp_pend0", pending, 3'd0);

      // flush with two queued entries and a full output register
      rob_stall = 1'b1;
      set_req(0, 32'h01, 5'd1, 1'b1, 3'd1);
      set_req(2, 32'h02, 5'd2, 1'b1, 3'd2);
      tick();
      req_valid = '0;
      set_req(1, 32'h03, 5'd3, 1'b1, 3'd3);
      tick();
      req_valid = '0;
      check("fl_pre_pend", pending, 3'd3);
      check("fl_pre_req", rob_req, 1'b1);
      flush = 1'b1;
      set_req(0, 32'h04, 5'd4, 1'b1, 3'd4);
      tick();
      flush = 1'b0;
      req_valid = '0;
      rob_stall = 1'b0;
      check("fl_pend", pending, 3'd0);
      check("fl_req", rob_req, 1'b0);
      check("fl_stall", req_stall, 3'b000);
      tick();
      tick();
      check("fl_noemit", rob_req, 1'b0);
      check("fl_pend_end", pending, 3'd0);

      // asynchronous reset while rob_req is high
      rob_stall = 1'b1;
      set_req(0, 32'h55, 5'd6, 1'b1, 3'd5);
      tick();
      req_valid = '0;
      tick();
      check("ar_pre", rob_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_req", rob_req, 1'b0);
      check("ar_pend", pending, 3'd0);
      check("ar_data", rob_data, 32'h0);
      rob_stall = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("ar_after", rob_req, 1'b0);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
